// File: rtl/order_message_encoder.sv
// Order-to-message serializer: one accepted order becomes a header word
// followed by two body words, all outputs driven straight from registers.
module order_message_encoder #(
    parameter int PRICE_WIDTH = 15,
    parameter int ID_WIDTH    = 15,
    parameter int QUANT_WIDTH = 7,
    parameter int STOCK_WIDTH = 7,
    parameter int DATA_WIDTH  = 31
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [2:0]            operation_in,
    input  logic [STOCK_WIDTH:0]  stock_symbol_in,
    input  logic [ID_WIDTH:0]     order_id_in,
    input  logic [PRICE_WIDTH:0]  price_in,
    input  logic [QUANT_WIDTH:0]  quantity_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH:0]   data_out,
    output logic                  enable_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic [15:0]           sent_count_out,
    output logic [7:0]            drop_count_out
);

    typedef enum logic [1:0] {IDLE, HDR, BODY1, BODY2} state_t;

    state_t              state_q;
    logic                ready_q;
    logic                enable_q;
    logic                valid_q;
    logic                last_q;
    logic [DATA_WIDTH:0] data_q;
    logic [DATA_WIDTH:0] body1_q;
    logic [15:0]         price_q;
    logic [15:0]         sent_q;
    logic [7:0]          drop_q;

    logic [DATA_WIDTH:0] hdr_d;
    logic [DATA_WIDTH:0] body1_d;
    logic [15:0]         price_d;

    // Narrow fields are zero-extended into their fixed slots.
    always_comb begin
        hdr_d   = {21'b0, operation_in, 8'd3};
        body1_d = {8'(stock_symbol_in), 8'(quantity_in), 16'(order_id_in)};
        price_d = 16'(price_in);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            enable_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            body1_q  <= '0;
            price_q  <= '0;
            sent_q   <= '0;
            drop_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        if (operation_in <= 3'd4) begin
                            body1_q  <= body1_d;
                            price_q  <= price_d;
                            data_q   <= hdr_d;
                            enable_q <= 1'b1;
                            ready_q  <= 1'b0;
                            state_q  <= HDR;
                        end else if (drop_q != 8'hFF) begin
                            drop_q <= drop_q + 8'd1;
                        end
                    end
                end
                HDR: begin
                    if (ready_in) begin
                        data_q   <= body1_q;
                        enable_q <= 1'b0;
                        valid_q  <= 1'b1;
                        state_q  <= BODY1;
                    end
                end
                BODY1: begin
                    if (ready_in) begin
                        data_q  <= {16'b0, price_q};
                        last_q  <= 1'b1;
                        state_q <= BODY2;
                    end
                end
                BODY2: begin
                    if (ready_in) begin
                        data_q  <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        ready_q <= 1'b1;
                        sent_q  <= sent_q + 16'd1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_out      = ready_q;
    assign enable_out     = enable_q;
    assign valid_out      = valid_q;
    assign last_out       = last_q;
    assign data_out       = data_q;
    assign sent_count_out = sent_q;
    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_order_message_encoder.sv
// Directed bench for order_message_encoder: inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_order_message_encoder;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [2:0]  operation_in;
    logic [7:0]  stock_symbol_in;
    logic [15:0] order_id_in;
    logic [15:0] price_in;
    logic [7:0]  quantity_in;
    logic        valid_in;
    logic        ready_out;
    logic        ready_in;
    logic [31:0] data_out;
    logic        enable_out;
    logic        valid_out;
    logic        last_out;
    logic [15:0] sent_count_out;
    logic [7:0]  drop_count_out;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    logic [15:0] exp_sent = 16'd0;
    logic [7:0]  exp_drop = 8'd0;

    order_message_encoder #(
        .PRICE_WIDTH(15), .ID_WIDTH(15), .QUANT_WIDTH(7), .STOCK_WIDTH(7), .DATA_WIDTH(31)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .operation_in(operation_in),
        .stock_symbol_in(stock_symbol_in), .order_id_in(order_id_in), .price_in(price_in),
        .quantity_in(quantity_in), .valid_in(valid_in), .ready_out(ready_out),
        .ready_in(ready_in), .data_out(data_out), .enable_out(enable_out),
        .valid_out(valid_out), .last_out(last_out), .sent_count_out(sent_count_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in)
        if (!reset_in && (enable_out || valid_out) && ready_in) xfers++;

    task automatic set_order(input logic [2:0] op, input logic [7:0] stk, input logic [7:0] qty,
                             input logic [15:0] id, input logic [15:0] pr);
        operation_in = op; stock_symbol_in = stk; quantity_in = qty;
        order_id_in = id; price_in = pr;
    endtask

    task automatic test_reset;
        reset_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        set_order(3'd0, 8'd0, 8'd0, 16'd0, 16'd0);
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        total++;
        if ({ready_out, enable_out, valid_out, last_out} !== 4'b1000) begin
            bad++; $display("FAIL reset_strobes: got %b want 1000", {ready_out, enable_out, valid_out, last_out});
        end
        total++;
        if (data_out !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 00000000", data_out); end
        total++;
        if (sent_count_out !== 16'd0 || drop_count_out !== 8'd0) begin
            bad++; $display("FAIL reset_counts: got sent=%0d drop=%0d want 0 0", sent_count_out, drop_count_out);
        end
        exp_sent = 16'd0; exp_drop = 8'd0;
    endtask

    task automatic test_basic;
        int x0;
        x0 = xfers;
        @(negedge clk_in);
        set_order(3'd1, 8'h41, 8'h10, 16'h1234, 16'hBEEF); valid_in = 1'b1;
        @(negedge clk_in); valid_in = 1'b0;
        set_order(3'd2, 8'h00, 8'h00, 16'h0000, 16'h0000);
        total++;
        if (data_out !== 32'h00000103 || enable_out !== 1'b1 || valid_out !== 1'b0 || ready_out !== 1'b0) begin
            bad++; $display("FAIL basic_hdr: got %h en=%b v=%b rdy=%b want 00000103 1 0 0", data_out, enable_out, valid_out, ready_out);
        end
        @(negedge clk_in);
        total++;
        if (data_out !== 32'h41101234 || valid_out !== 1'b1 || enable_out !== 1'b0 || last_out !== 1'b0) begin
            bad++; $display("FAIL basic_body1: got %h v=%b en=%b l=%b want 41101234 1 0 0", data_out, valid_out, enable_out, last_out);
        end
        @(negedge clk_in);
        total++;
        if (data_out !== 32'h0000BEEF || valid_out !== 1'b1 || last_out !== 1'b1) begin
            bad++; $display("FAIL basic_body2: got %h v=%b l=%b want 0000beef 1 1", data_out, valid_out, last_out);
        end
        @(negedge clk_in);
        exp_sent = exp_sent + 16'd1;
        total++;
        if (sent_count_out !== exp_sent || ready_out !== 1'b1 || valid_out !== 1'b0 || data_out !== 32'd0) begin
            bad++; $display("FAIL basic_done: got sent=%0d rdy=%b v=%b d=%h want %0d 1 0 0", sent_count_out, ready_out, valid_out, data_out, exp_sent);
        end
        total++;
        if (xfers - x0 !== 3) begin bad++; $display("FAIL basic_xfers: got %0d want 3", xfers - x0); end
    endtask

    task automatic test_backpressure;
        int x0;
        x0 = xfers;
        set_order(3'd1, 8'h41, 8'h10, 16'h1234, 16'hBEEF); valid_in = 1'b1;
        @(negedge clk_in); valid_in = 1'b0;
        total++;
        if (data_out !== 32'h00000103 || enable_out !== 1'b1) begin
            bad++; $display("FAIL bp_hdr: got %h en=%b want 00000103 1", data_out, enable_out);
        end
        @(negedge clk_in); ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (data_out !== 32'h41101234 || valid_out !== 1'b1 || last_out !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d: got %h v=%b l=%b want 41101234 1 0", i, data_out, valid_out, last_out);
            end
            if (i < 3) @(negedge clk_in);
        end
        ready_in = 1'b1;
        @(negedge clk_in);
        total++;
        if (data_out !== 32'h0000BEEF || last_out !== 1'b1) begin
            bad++; $display("FAIL bp_body2: got %h l=%b want 0000beef 1", data_out, last_out);
        end
        @(negedge clk_in);
        exp_sent = exp_sent + 16'd1;
        total++;
        if (sent_count_out !== exp_sent || xfers - x0 !== 3) begin
            bad++; $display("FAIL bp_done: got sent=%0d xfers=%0d want %0d 3", sent_count_out, xfers - x0, exp_sent);
        end
    endtask

    task automatic test_illegal_op;
        int x0;
        x0 = xfers;
        set_order(3'd7, 8'h41, 8'h10, 16'h1234, 16'hBEEF); valid_in = 1'b1;
        @(negedge clk_in); valid_in = 1'b0;
        exp_drop = exp_drop + 8'd1;
        total++;
        if (drop_count_out !== exp_drop || ready_out !== 1'b1 || enable_out !== 1'b0 || valid_out !== 1'b0) begin
            bad++; $display("FAIL illegal_op: got drop=%0d rdy=%b en=%b v=%b want %0d 1 0 0", drop_count_out, ready_out, enable_out, valid_out, exp_drop);
        end
        @(negedge clk_in);
        total++;
        if (xfers - x0 !== 0 || enable_out !== 1'b0 || sent_count_out !== exp_sent) begin
            bad++; $display("FAIL illegal_quiet: got xfers=%0d en=%b sent=%0d want 0 0 %0d", xfers - x0, enable_out, sent_count_out, exp_sent);
        end
    endtask

    task automatic test_drop_saturation;
        set_order(3'd5, 8'h00, 8'h00, 16'h0000, 16'h0000); valid_in = 1'b1;
        repeat (260) @(negedge clk_in);
        valid_in = 1'b0;
        @(negedge clk_in);
        exp_drop = 8'd255;
        total++;
        if (drop_count_out !== exp_drop || ready_out !== 1'b1) begin
            bad++; $display("FAIL drop_sat: got drop=%0d rdy=%b want 255 1", drop_count_out, ready_out);
        end
    endtask

    task automatic test_back_to_back;
        int x0;
        logic [31:0] want [6];
        want = '{32'h00000103, 32'h41101234, 32'h0000BEEF, 32'h00000403, 32'hFF010000, 32'h0000FFFF};
        x0 = xfers;
        set_order(3'd1, 8'h41, 8'h10, 16'h1234, 16'hBEEF); valid_in = 1'b1;
        @(negedge clk_in);
        set_order(3'd4, 8'hFF, 8'h01, 16'h0000, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (data_out !== want[i]) begin bad++; $display("FAIL b2b_a%0d: got %h want %h", i, data_out, want[i]); end
            @(negedge clk_in);
        end
        exp_sent = exp_sent + 16'd1;
        total++;
        if (ready_out !== 1'b1 || sent_count_out !== exp_sent || valid_out !== 1'b0) begin
            bad++; $display("FAIL b2b_gap: got rdy=%b sent=%0d v=%b want 1 %0d 0", ready_out, sent_count_out, valid_out, exp_sent);
        end
        @(negedge clk_in); valid_in = 1'b0;
        for (int i = 3; i < 6; i++) begin
            total++;
            if (data_out !== want[i]) begin bad++; $display("FAIL b2b_b%0d: got %h want %h", i, data_out, want[i]); end
            @(negedge clk_in);
        end
        exp_sent = exp_sent + 16'd1;
        total++;
        if (sent_count_out !== exp_sent || xfers - x0 !== 6) begin
            bad++; $display("FAIL b2b_done: got sent=%0d xfers=%0d want %0d 6", sent_count_out, xfers - x0, exp_sent);
        end
    endtask

    task automatic test_reset_mid_message;
        set_order(3'd3, 8'h41, 8'h10, 16'h1234, 16'hBEEF); valid_in = 1'b1;
        @(negedge clk_in); valid_in = 1'b0;
        @(negedge clk_in);
        total++;
        if (valid_out !== 1'b1 || data_out !== 32'h41101234) begin
            bad++; $display("FAIL rstmid_pre: got v=%b d=%h want 1 41101234", valid_out, data_out);
        end
        reset_in = 1'b1; valid_in = 1'b1;
        @(negedge clk_in);
        total++;
        if ({ready_out, enable_out, valid_out, last_out} !== 4'b1000 || data_out !== 32'd0 || sent_count_out !== 16'd0) begin
            bad++; $display("FAIL rstmid_state: got %b d=%h sent=%0d want 1000 0 0", {ready_out, enable_out, valid_out, last_out}, data_out, sent_count_out);
        end
        @(negedge clk_in);
        total++;
        if (enable_out !== 1'b0 || ready_out !== 1'b1 || drop_count_out !== 8'd0) begin
            bad++; $display("FAIL rst_vs_valid: got en=%b rdy=%b drop=%0d want 0 1 0", enable_out, ready_out, drop_count_out);
        end
        reset_in = 1'b0;
        exp_sent = 16'd0; exp_drop = 8'd0;
        set_order(3'd0, 8'h07, 8'h80, 16'hA5A5, 16'h0001);
        @(negedge clk_in); valid_in = 1'b0;
        total++;
        if (data_out !== 32'h00000003 || enable_out !== 1'b1) begin
            bad++; $display("FAIL fresh_hdr: got %h en=%b want 00000003 1", data_out, enable_out);
        end
        @(negedge clk_in);
        total++;
        if (data_out !== 32'h0780A5A5) begin bad++; $display("FAIL fresh_body1: got %h want 0780a5a5", data_out); end
        @(negedge clk_in);
        total++;
        if (data_out !== 32'h00000001 || last_out !== 1'b1) begin
            bad++; $display("FAIL fresh_body2: got %h l=%b want 00000001 1", data_out, last_out);
        end
        @(negedge clk_in);
        exp_sent = exp_sent + 16'd1;
        total++;
        if (sent_count_out !== exp_sent) begin bad++; $display("FAIL fresh_sent: got %0d want %0d", sent_count_out, exp_sent); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal_op();
        test_drop_saturation();
        test_back_to_back();
        test_reset_mid_message();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
